// File: rtl/stack_row_engine.sv
// Block-stacker row engine: sweeps an n-wide block row across COLS columns and,
// on drop, trims the stack top to the overlap (success) or reports a miss.
module stack_row_engine #(
  parameter int COLS     = 8,
  parameter int PRESCALE = 50000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            drop,
  input  logic [3:0]      speed,
  input  logic [3:0]      num_blocks,
  input  logic [3:0]      curr_level,
  output logic [COLS-1:0] row_mask,
  output logic [COLS-1:0] base_mask,
  output logic            active,
  output logic            next_signal,
  output logic            fail
);
  localparam int PW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NW = $clog2(COLS + 1);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, MOVE, JUDGE} state_t;
  state_t state, state_nx;

  logic [NW-1:0]   n_r, n_ld;
  logic [3:0]      s_r, s_ld;
  logic [PW-1:0]   pos, pos_nx, pos_max;
  logic            dir_left, dir_nx;
  logic [CW-1:0]   presc;
  logic [3:0]      step;
  logic            wrap, step_done, tick;
  logic [COLS-1:0] overlap;

  function automatic logic [COLS-1:0] span(input logic [NW-1:0] cnt, input logic [PW-1:0] p);
    logic [COLS-1:0] m;
    for (int i = 0; i < COLS; i++)
      m[i] = (i >= int'(p)) && (i < int'(p) + int'(cnt));
    return m;
  endfunction

  assign n_ld      = (num_blocks == 4'd0)       ? NW'(1)    :
                     (int'(num_blocks) > COLS)  ? NW'(COLS) : NW'(num_blocks);
  assign s_ld      = (speed == 4'd0) ? 4'd1 : speed;
  assign wrap      = (presc == CW'(PRESCALE - 1));
  assign step_done = (step == 4'd15 - s_r);
  // A full-width row has nowhere to go, so ticks are swallowed.
  assign tick      = wrap && step_done && (n_r != NW'(COLS));
  assign pos_max   = PW'(COLS - int'(n_r));
  assign overlap   = row_mask & base_mask;
  assign active    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = MOVE;
      MOVE:    if (drop) state_nx = JUDGE;
      JUDGE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bounce: reverse at either wall, stepping away from it on the same tick.
  always_comb begin
    pos_nx = pos;
    dir_nx = dir_left;
    if (!dir_left) begin
      if (pos == pos_max) begin dir_nx = 1'b1; pos_nx = pos - PW'(1); end
      else                pos_nx = pos + PW'(1);
    end else begin
      if (pos == '0) begin dir_nx = 1'b0; pos_nx = pos + PW'(1); end
      else           pos_nx = pos - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_mask    <= '0;
      base_mask   <= '1;
      next_signal <= 1'b0;
      fail        <= 1'b0;
      n_r         <= NW'(1);
      s_r         <= 4'd1;
      pos         <= '0;
      dir_left    <= 1'b0;
      presc       <= '0;
      step        <= '0;
    end else begin
      next_signal <= 1'b0;
      fail        <= 1'b0;
      case (state)
        IDLE: row_mask <= '0;
        LOAD: begin
          n_r      <= n_ld;
          s_r      <= s_ld;
          pos      <= '0;
          dir_left <= 1'b0;
          presc    <= '0;
          step     <= '0;
          row_mask <= span(n_ld, '0);
          if (curr_level == 4'd1) base_mask <= '1;
        end
        MOVE: if (!drop) begin
          // drop freezes everything, so the pre-tick row is what gets judged
          if (wrap) begin
            presc <= '0;
            step  <= step_done ? 4'd0 : step + 4'd1;
          end else begin
            presc <= presc + CW'(1);
          end
          if (tick) begin
            pos      <= pos_nx;
            dir_left <= dir_nx;
            row_mask <= span(n_r, pos_nx);
          end
        end
        JUDGE: begin
          row_mask <= '0;
          if (overlap != '0) begin
            base_mask   <= overlap;
            next_signal <= 1'b1;
          end else begin
            base_mask   <= '1;
            fail        <= 1'b1;
          end
        end
        default: row_mask <= '0;
      endcase
    end
  end
endmodule
